// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the EX-stage ALU control and multiply/divide sequencer.
// Holds ALUOp codes, R-type function codes, ALU operation codes and the
// sequencer FSM state encoding.
package alu_ctrl_pkg;

  // ALUOp codes from the main control unit
  localparam logic [2:0] AluOpRtype  = 3'b111;
  localparam logic [2:0] AluOpAddi   = 3'b100;
  localparam logic [2:0] AluOpOri    = 3'b101;
  localparam logic [2:0] AluOpAndi   = 3'b110;
  localparam logic [2:0] AluOpBranch = 3'b001;

  // R-type function field codes
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnMult = 6'b011000;
  localparam logic [5:0] FnDiv  = 6'b011010;
  localparam logic [5:0] FnJr   = 6'b001000;

  // ALU operation codes; OpIllegal doubles as the JR code
  localparam logic [3:0] OpAnd     = 4'b0000;
  localparam logic [3:0] OpOr      = 4'b0001;
  localparam logic [3:0] OpNor     = 4'b0010;
  localparam logic [3:0] OpAdd     = 4'b0011;
  localparam logic [3:0] OpSub     = 4'b0100;
  localparam logic [3:0] OpSll     = 4'b0101;
  localparam logic [3:0] OpSrl     = 4'b0110;
  localparam logic [3:0] OpMult    = 4'b0111;
  localparam logic [3:0] OpDiv     = 4'b1000;
  localparam logic [3:0] OpIllegal = 4'b1001;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } md_state_e;

endpackage

// File: rtl/alu_control_mc_md_seq_counter.sv
// md_seq_counter: loadable down-counter with a zero flag, used to time
// multi-cycle MDU operations. Decrement saturates at zero.
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset (count returns to 0)
//   load     load load_val (has priority over dec)
//   load_val value to load
//   dec      decrement by one when non-zero
//   zero     count is zero
module md_seq_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/alu_control_mc.sv
// alu_control_mc: EX-stage ALU control. Decodes ALUOp plus the R-type function
// field into an ALU operation code and JR flag, and sequences multi-cycle
// MULT/DIV operations on the external MDU with a pipeline stall handshake.
// Optional feature macro: ALU_CTRL_DIV_EN (DIV decode and sequencing).
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   valid, flush      EX instruction valid / being squashed
//   alu_op            ALUOp from control unit
//   alu_function      instruction function field
//   alu_operation     ALU operation code (combinational)
//   jr                JR decoded (combinational)
//   illegal           valid instruction with no legal decode (combinational)
//   stall             freeze PC/IF/ID/EX
//   md_start          one-cycle MDU start pulse
//   md_op             0 = MULT, 1 = DIV; stable while busy
//   hilo_we           one-cycle HI/LO write enable at completion
module alu_control_mc
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned FUNCT_W  = 6,
  parameter int unsigned OP_W     = 4,
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  input  logic               flush,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] alu_function,
  output logic [OP_W-1:0]    alu_operation,
  output logic               jr,
  output logic               illegal,
  output logic               stall,
  output logic               md_start,
  output logic               md_op,
  output logic               hilo_we
);

  if (MULT_LAT < 2 || DIV_LAT < 2) begin : gen_bad_lat
    $error("alu_control_mc: MULT_LAT and DIV_LAT must be at least 2");
  end

`ifdef ALU_CTRL_DIV_EN
  localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
`else
  localparam int unsigned MaxLat = MULT_LAT;
`endif
  localparam int unsigned CntW = (MaxLat > 1) ? $clog2(MaxLat) : 1;

  // Cycle 0 (start) and the final RUN cycle are not counted, hence LAT-2.
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_LAT - 2);
`ifdef ALU_CTRL_DIV_EN
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_LAT - 2);
`endif

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [3:0] op_code;
  logic       dec_ok;
  logic       is_mult;
  logic       is_div;

  always_comb begin
    op_code = OpIllegal;
    dec_ok  = 1'b0;
    jr      = 1'b0;
    is_mult = 1'b0;
    is_div  = 1'b0;
    case (alu_op)
      ALUOP_W'(AluOpRtype): begin
        dec_ok = 1'b1;
        case (alu_function)
          FUNCT_W'(FnAnd):  op_code = OpAnd;
          FUNCT_W'(FnOr):   op_code = OpOr;
          FUNCT_W'(FnNor):  op_code = OpNor;
          FUNCT_W'(FnAdd):  op_code = OpAdd;
          FUNCT_W'(FnSub):  op_code = OpSub;
          FUNCT_W'(FnSll):  op_code = OpSll;
          FUNCT_W'(FnSrl):  op_code = OpSrl;
          FUNCT_W'(FnMult): begin
            op_code = OpMult;
            is_mult = 1'b1;
          end
`ifdef ALU_CTRL_DIV_EN
          FUNCT_W'(FnDiv): begin
            op_code = OpDiv;
            is_div  = 1'b1;
          end
`endif
          FUNCT_W'(FnJr): begin
            op_code = OpIllegal;
            jr      = 1'b1;
          end
          default: dec_ok = 1'b0;
        endcase
      end
      ALUOP_W'(AluOpAddi):   begin op_code = OpAdd; dec_ok = 1'b1; end
      ALUOP_W'(AluOpOri):    begin op_code = OpOr;  dec_ok = 1'b1; end
      ALUOP_W'(AluOpAndi):   begin op_code = OpAnd; dec_ok = 1'b1; end
      ALUOP_W'(AluOpBranch): begin op_code = OpSub; dec_ok = 1'b1; end
      default: ;
    endcase
  end

  assign alu_operation = OP_W'(op_code);
  assign illegal       = valid & ~dec_ok;

  // ---------------------------------------------------------------------------
  // Multi-cycle sequencer
  // ---------------------------------------------------------------------------
  md_state_e state_q, state_d;
  logic      cnt_load;
  logic      cnt_dec;
  logic      cnt_zero;
  logic      start_req;

  assign start_req = valid & ~flush & (is_mult | is_div);

  always_comb begin
    state_d  = state_q;
    md_start = 1'b0;
    stall    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          md_start = 1'b1;
          stall    = 1'b1;
          cnt_load = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        stall = 1'b1;
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_zero) begin
          state_d = StDone;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      // Completion cycle: ignores flush and any MULT/DIV still on the inputs.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign hilo_we = (state_q == StDone);

`ifdef ALU_CTRL_DIV_EN
  logic md_op_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_op_q <= 1'b0;
    end else if (cnt_load) begin
      md_op_q <= is_div;
    end
  end

  assign md_op = md_op_q;

  logic [CntW-1:0] load_val;
  assign load_val = is_div ? DivLoad : MultLoad;
`else
  assign md_op = 1'b0;

  logic [CntW-1:0] load_val;
  assign load_val = MultLoad;
`endif

  md_seq_counter #(
    .Width(CntW)
  ) u_md_seq_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed self-checking bench for alu_control_mc (default parameters).
module tb_alu_control_mc;

  logic       clk;
  logic       reset;
  logic       valid;
  logic       flush;
  logic [2:0] alu_op;
  logic [5:0] alu_function;
  logic [3:0] alu_operation;
  logic       jr;
  logic       illegal;
  logic       stall;
  logic       md_start;
  logic       md_op;
  logic       hilo_we;

  int tests;
  int fails;

`ifdef ALU_CTRL_DIV_EN
  localparam logic [3:0] DivExp = 4'b1000;
`else
  localparam logic [3:0] DivExp = 4'b1001;
`endif

  alu_control_mc dut (
    .clk           (clk),
    .reset         (reset),
    .valid         (valid),
    .flush         (flush),
    .alu_op        (alu_op),
    .alu_function  (alu_function),
    .alu_operation (alu_operation),
    .jr            (jr),
    .illegal       (illegal),
    .stall         (stall),
    .md_start      (md_start),
    .md_op         (md_op),
    .hilo_we       (hilo_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a MULT in IDLE and checks cycles 0..4; returns in cycle 4 (DONE)
  // with the MULT still on the inputs.
  task automatic run_mult(input string tag);
    alu_op = 3'b111; alu_function = 6'b011000; valid = 1'b1; flush = 1'b0;
    #1;
    tests++; if (md_start !== 1'b1) begin fails++; $display("FAIL %s c0 md_start got %b want 1", tag, md_start); end
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL %s c0 stall got %b want 1", tag, stall); end
    tests++; if (alu_operation !== 4'b0111) begin fails++; $display("FAIL %s c0 op got %b want 0111", tag, alu_operation); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL %s c%0d stall got %b want 1", tag, c, stall); end
      tests++; if (md_start !== 1'b0) begin fails++; $display("FAIL %s c%0d md_start got %b want 0", tag, c, md_start); end
      tests++; if (hilo_we !== 1'b0) begin fails++; $display("FAIL %s c%0d hilo_we got %b want 0", tag, c, hilo_we); end
      tests++; if (md_op !== 1'b0) begin fails++; $display("FAIL %s c%0d md_op got %b want 0", tag, c, md_op); end
    end
    tick();
    tests++; if (hilo_we !== 1'b1) begin fails++; $display("FAIL %s c4 hilo_we got %b want 1", tag, hilo_we); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL %s c4 stall got %b want 0", tag, stall); end
    tests++; if (md_start !== 1'b0) begin fails++; $display("FAIL %s c4 md_start got %b want 0", tag, md_start); end
  endtask

  task automatic test_reset();
    reset = 1'b0; valid = 1'b0; flush = 1'b0; alu_op = 3'b111; alu_function = 6'b100010;
    tick(); tick();
    tests++; if (alu_operation !== 4'b0100) begin fails++; $display("FAIL reset op got %b want 0100", alu_operation); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset stall got %b want 0", stall); end
    tests++; if (hilo_we !== 1'b0) begin fails++; $display("FAIL reset hilo_we got %b want 0", hilo_we); end
    tests++; if (md_start !== 1'b0) begin fails++; $display("FAIL reset md_start got %b want 0", md_start); end
    tests++; if (md_op !== 1'b0) begin fails++; $display("FAIL reset md_op got %b want 0", md_op); end
    reset = 1'b1;
    tick(); tick();
    tests++; if (alu_operation !== 4'b0100) begin fails++; $display("FAIL release op got %b want 0100", alu_operation); end
    tests++; if (stall !== 1'b0 || hilo_we !== 1'b0 || md_start !== 1'b0) begin
      fails++; $display("FAIL release ctl got stall=%b we=%b start=%b want 0 0 0", stall, hilo_we, md_start);
    end
  endtask

  task automatic test_mult();
    run_mult("mult");
    tick();
    valid = 1'b0;
    #1;
    tests++; if (stall !== 1'b0 || hilo_we !== 1'b0 || md_start !== 1'b0) begin
      fails++; $display("FAIL mult c5 idle got stall=%b we=%b start=%b want 0 0 0", stall, hilo_we, md_start);
    end
  endtask

  task automatic test_div();
    alu_op = 3'b111; alu_function = 6'b011010; valid = 1'b1; flush = 1'b0;
    #1;
`ifdef ALU_CTRL_DIV_EN
    tests++; if (md_start !== 1'b1 || stall !== 1'b1) begin
      fails++; $display("FAIL div c0 got start=%b stall=%b want 1 1", md_start, stall);
    end
    for (int c = 1; c <= 31; c++) begin
      tick();
      tests++; if (stall !== 1'b1 || md_op !== 1'b1 || hilo_we !== 1'b0) begin
        fails++; $display("FAIL div c%0d got stall=%b md_op=%b we=%b want 1 1 0", c, stall, md_op, hilo_we);
      end
    end
    tick();
    tests++; if (hilo_we !== 1'b1 || stall !== 1'b0 || md_op !== 1'b1) begin
      fails++; $display("FAIL div c32 got we=%b stall=%b md_op=%b want 1 0 1", hilo_we, stall, md_op);
    end
`else
    tests++; if (illegal !== 1'b1) begin fails++; $display("FAIL div illegal got %b want 1", illegal); end
    tests++; if (alu_operation !== 4'b1001) begin fails++; $display("FAIL div op got %b want 1001", alu_operation); end
    tests++; if (stall !== 1'b0 || md_start !== 1'b0) begin
      fails++; $display("FAIL div nostart got stall=%b start=%b want 0 0", stall, md_start);
    end
    tick();
    tests++; if (stall !== 1'b0 || hilo_we !== 1'b0 || md_op !== 1'b0) begin
      fails++; $display("FAIL div idle got stall=%b we=%b md_op=%b want 0 0 0", stall, hilo_we, md_op);
    end
`endif
    tick();
    valid = 1'b0;
    #1;
    tests++; if (stall !== 1'b0 || hilo_we !== 1'b0) begin
      fails++; $display("FAIL div end got stall=%b we=%b want 0 0", stall, hilo_we);
    end
  endtask

  task automatic test_flush();
    alu_op = 3'b111; alu_function = 6'b011000; valid = 1'b1; flush = 1'b0;
    #1;
    tests++; if (md_start !== 1'b1) begin fails++; $display("FAIL flush c0 md_start got %b want 1", md_start); end
    tick();
    tick();
    flush = 1'b1;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL flush c2 stall got %b want 1", stall); end
    tick();
    flush = 1'b0; valid = 1'b0;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush c3 stall got %b want 0", stall); end
    for (int c = 0; c < 4; c++) begin
      tests++; if (hilo_we !== 1'b0) begin fails++; $display("FAIL flush no_we c%0d got %b want 0", c + 3, hilo_we); end
      tick();
    end
    run_mult("flush_restart");
    tick();
    valid = 1'b0;
    #1;
  endtask

  task automatic test_decode();
    logic [2:0] ops [16];
    logic [5:0] fns [16];
    logic [3:0] exp [16];
    logic       ejr [16];
    logic       eill;
    ops = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
            3'b111, 3'b111, 3'b100, 3'b101, 3'b110, 3'b001, 3'b011, 3'b111};
    fns = '{6'b100100, 6'b100101, 6'b100111, 6'b100000, 6'b100010, 6'b000000,
            6'b000010, 6'b011000, 6'b011010, 6'b001000, 6'b101010, 6'b111111,
            6'b000000, 6'b011000, 6'b100000, 6'b111111};
    exp = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
            DivExp,  4'b1001, 4'b0011, 4'b0001, 4'b0000, 4'b0100, 4'b1001, 4'b1001};
    ejr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    flush = 1'b0;
    valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      alu_op = ops[i]; alu_function = fns[i];
      #1;
      tests++; if (alu_operation !== exp[i] || jr !== ejr[i] || illegal !== 1'b0 || stall !== 1'b0) begin
        fails++;
        $display("FAIL decode[%0d] %b/%b got op=%b jr=%b ill=%b stall=%b want op=%b jr=%b ill=0 stall=0",
                 i, ops[i], fns[i], alu_operation, jr, illegal, stall, exp[i], ejr[i]);
      end
    end
    // Valid sweep skips MULT/DIV, which would start a sequence.
    valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 7 || i == 8) continue;
      alu_op = ops[i]; alu_function = fns[i];
      eill = (exp[i] == 4'b1001) && !ejr[i];
      #1;
      tests++; if (illegal !== eill) begin
        fails++; $display("FAIL illegal[%0d] %b/%b got %b want %b", i, ops[i], fns[i], illegal, eill);
      end
    end
    valid = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    run_mult("b2b_first");
    tick();
    run_mult("b2b_second");
    tick();
    valid = 1'b0;
    #1;
    tests++; if (stall !== 1'b0 || hilo_we !== 1'b0) begin
      fails++; $display("FAIL b2b end got stall=%b we=%b want 0 0", stall, hilo_we);
    end
  endtask

  task automatic test_reset_mid_run();
    alu_op = 3'b111; alu_function = 6'b011000; valid = 1'b1; flush = 1'b0;
    tick();
    tick();
    valid = 1'b0;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rst_run pre stall got %b want 1", stall); end
    reset = 1'b0;
    #1;
    tests++; if (stall !== 1'b0 || hilo_we !== 1'b0) begin
      fails++; $display("FAIL rst_run async got stall=%b we=%b want 0 0", stall, hilo_we);
    end
    tick();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      tests++; if (hilo_we !== 1'b0 || stall !== 1'b0) begin
        fails++; $display("FAIL rst_run after c%0d got we=%b stall=%b want 0 0", c, hilo_we, stall);
      end
    end
    run_mult("rst_run_restart");
    tick();
    valid = 1'b0;
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    tick();
    test_mult();
    tick();
    test_div();
    tick();
    test_flush();
    tick();
    test_decode();
    tick();
    test_back_to_back();
    tick();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
